ain_conditioner: RTL and testbench

- Upstream stage that produces the 2-bit `ain` code consumed by the Moore pattern-detector FSM (set/clear/toggle on code followed by two 00s).
- Takes two raw asynchronous switch/button bits, synchronises and debounces each, then qualifies the pair so the FSM sees one clean code transition per operator action and never a skew-induced intermediate code (e.g. 01 during 00->11).
- Also emits a one-cycle change strobe for logging and LEDs.

---
 rtl/ain_conditioner.sv | 89 ++++++++
 tb/tb_ain_conditioner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ain_conditioner.sv
// rtl/ain_conditioner.sv - synchronise, debounce and pair-qualify two raw switch bits into the FSM ain code
module ain_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw_in,
  output logic [1:0] ain,
  output logic       ain_chg
);

  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_TERM = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       s1_q, s2_q;
  logic [1:0]       db_q, db_d;
  logic [1:0]       db_dly_q;
  logic [CNT_W-1:0] dcnt_q [2];
  logic [CNT_W-1:0] dcnt_d [2];
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [1:0]       ain_q, ain_d;
  logic             chg_q, chg_d;

  // Per-bit debounce: a bit must disagree with db for DEBOUNCE_CYCLES straight clocks to flip it
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DB_TERM) begin
        db_d[i]   = s2_q[i];
        dcnt_d[i] = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + CNT_ONE;
      end
    end
  end

  // Pair qualifier: only hand a new code to ain once both debounced bits have stopped moving
  always_comb begin
    ain_d  = ain_q;
    chg_d  = 1'b0;
    pcnt_d = pcnt_q;
    if (db_q == ain_q) begin
      pcnt_d = '0;
    end else if (db_q != db_dly_q) begin
      pcnt_d = '0;
    end else if (pcnt_q == ST_TERM) begin
      ain_d  = db_q;
      chg_d  = 1'b1;
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + CNT_ONE;
    end
  end

  // State registers: two-flop synchroniser, debounce, pair qualifier and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_dly_q  <= '0;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
      pcnt_q    <= '0;
      ain_q     <= '0;
      chg_q     <= 1'b0;
    end else begin
      s1_q      <= raw_in;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_dly_q  <= db_q;
      dcnt_q[0] <= dcnt_d[0];
      dcnt_q[1] <= dcnt_d[1];
      pcnt_q    <= pcnt_d;
      ain_q     <= ain_d;
      chg_q     <= chg_d;
    end
  end

  assign ain     = ain_q;
  assign ain_chg = chg_q;

endmodule

// File: tb/tb_ain_conditioner.sv
// tb/tb_ain_conditioner.sv - scoreboard bench for ain_conditioner
module tb_ain_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] raw_in;
  logic [1:0] ain;
  logic       ain_chg;

  ain_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES  (2),
    .CNT_W          (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_in (raw_in),
    .ain    (ain),
    .ain_chg(ain_chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  code;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  prev_ain = 2'b00;

  // edge counter: after posedge number k, cyc reads k
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops one expectation per ain_chg pulse
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (ain !== 2'b00 || ain_chg !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: ain=%b ain_chg=%b, required ain=00 ain_chg=0", ain, ain_chg);
      end
    end else begin
      if (ain_chg === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_chg: ain_chg=1 ain=%b at cycle %0d, required no pulse", ain, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (ain !== e.code) begin
            errors++;
            $display("FAIL chg_code: ain=%b, required %b", ain, e.code);
          end
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL chg_cycle: pulse at cycle %0d, required %0d", cyc, e.cyc);
          end
        end
      end else if (ain !== prev_ain) begin
        checks++;
        errors++;
        $display("FAIL silent_change: ain %b->%b without ain_chg at cycle %0d, required pulse", prev_ain, ain, cyc);
      end
    end
    prev_ain = ain;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // drive raw_in now; expect ain=code once the first sampling edge plus 8 edges have passed
  task automatic drive_expect(input logic [1:0] v, input logic [1:0] code, input int extra);
    exp_t e;
    raw_in = v;
    e.code = code;
    e.cyc  = cyc + 9 + extra;
    exp_q.push_back(e);
  endtask

  task automatic check_ain(input string name, input logic [1:0] want);
    checks++;
    if (ain !== want || ain_chg !== 1'b0) begin
      errors++;
      $display("FAIL %s: ain=%b ain_chg=%b, required ain=%b ain_chg=0", name, ain, ain_chg, want);
    end
  endtask

  initial begin
    reset  = 1'b1;
    raw_in = 2'b11;

    // 1: reset held 3 cycles with raw_in=11, then full latency to 11
    tick(3);
    reset = 1'b0;
    begin
      exp_t e;
      e.code = 2'b11;
      e.cyc  = cyc + 9;
      exp_q.push_back(e);
    end
    tick(15);
    check_ain("t1_hold_11", 2'b11);

    // 2: back to 00, then 00->10 held
    drive_expect(2'b00, 2'b00, 0);
    tick(15);
    check_ain("t2_back_00", 2'b00);
    drive_expect(2'b10, 2'b10, 0);
    tick(25);
    check_ain("t2_hold_10", 2'b10);
    drive_expect(2'b00, 2'b00, 0);
    tick(15);

    // 3: bit1 glitch of 3 clocks never reaches ain
    raw_in = 2'b10;
    tick(3);
    raw_in = 2'b00;
    tick(20);
    check_ain("t3_glitch", 2'b00);

    // 4: bit0 then bit1 one clock later -> single move to 11
    drive_expect(2'b01, 2'b11, 1);
    tick(1);
    raw_in = 2'b11;
    tick(20);
    check_ain("t4_skew_11", 2'b11);
    drive_expect(2'b00, 2'b00, 0);
    tick(15);
    check_ain("t4_back_00", 2'b00);

    // 5: bit0 bouncing every 2 clocks for 20 clocks, then stable high
    for (int p = 0; p < 5; p++) begin
      raw_in = 2'b01;
      tick(2);
      raw_in = 2'b00;
      tick(2);
    end
    check_ain("t5_bounce", 2'b00);
    drive_expect(2'b01, 2'b01, 0);
    tick(20);
    check_ain("t5_hold_01", 2'b01);
    drive_expect(2'b00, 2'b00, 0);
    tick(15);

    // 6: reset while the pair counter is mid-count for 11
    raw_in = 2'b11;
    tick(7);
    reset = 1'b1;
    tick(2);
    check_ain("t6_in_reset", 2'b00);
    reset = 1'b0;
    begin
      exp_t e;
      e.code = 2'b11;
      e.cyc  = cyc + 9;
      exp_q.push_back(e);
    end
    tick(7);
    check_ain("t6_not_yet", 2'b00);
    tick(15);
    check_ain("t6_hold_11", 2'b11);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_chg: %0d expected pulses not seen, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
